cmd_dispatch: RTL



---
 rtl/cmd_dispatch_if.sv | 28 ++
 rtl/cmd_dispatch.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/cmd_dispatch_if.sv
// Command/response link between UART_wrapper and cmd_dispatch.
// Wrapper drives commands and send-done; dispatcher answers.
interface cmd_dispatch_if;
  logic        cmd_rdy;
  logic [15:0] cmd;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic [7:0]  resp;
  logic        resp_sent;

  modport master (
    output cmd_rdy,
    output cmd,
    output resp_sent,
    input  clr_cmd_rdy,
    input  send_resp,
    input  resp
  );

  modport slave (
    input  cmd_rdy,
    input  cmd,
    input  resp_sent,
    output clr_cmd_rdy,
    output send_resp,
    output resp
  );
endinterface

// File: rtl/cmd_dispatch.sv
// Serial command executor: config register bank, calibration
// launch/monitor, one command in flight, one response per command.
module cmd_dispatch #(
  parameter int         CAL_TMO = 1024,
  parameter logic [7:0] ACK     = 8'hA5,
  parameter logic [7:0] NAK     = 8'hEE
) (
  input  logic           clk,
  input  logic           rst,
  cmd_dispatch_if.slave  u_if,
  output logic           strt_cal,
  input  logic           cal_done,
  output logic [31:0]    cfg_regs,
  output logic           busy
);

  localparam int CW = $clog2(CAL_TMO);
  localparam logic [CW-1:0] CNT_LAST = CW'(CAL_TMO - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_CAL_WAIT,
    S_RESP,
    S_WAIT_SENT
  } state_t;

  state_t          r_state;
  logic [15:0]     r_cmd;
  logic [3:0][7:0] r_regs;
  logic [7:0]      r_resp;
  logic [CW-1:0]   r_cnt;
  logic            r_clr;
  logic            r_send;
  logic            r_strt;
  logic            r_busy;

  logic [3:0] w_op;
  logic [3:0] w_addr;
  logic [7:0] w_data;
  logic [1:0] w_idx;
  logic       w_addr_ok;
  logic       w_op_ping;
  logic       w_op_wr;
  logic       w_op_rd;
  logic       w_op_cal;

  assign w_op      = r_cmd[15:12];
  assign w_addr    = r_cmd[11:8];
  assign w_data    = r_cmd[7:0];
  assign w_idx     = w_addr[1:0];
  assign w_addr_ok = (w_addr[3:2] == 2'b00);
  assign w_op_ping = (w_op == 4'h0);
  assign w_op_wr   = (w_op == 4'h1);
  assign w_op_rd   = (w_op == 4'h2);
  assign w_op_cal  = (w_op == 4'h3);

  assign u_if.clr_cmd_rdy = r_clr;
  assign u_if.send_resp   = r_send;
  assign u_if.resp        = r_resp;
  assign strt_cal         = r_strt;
  assign cfg_regs         = r_regs;
  assign busy             = r_busy;

  // Command FSM; pulses are registered on the transition into
  // the cycle where they must be seen.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cmd   <= '0;
      r_regs  <= '0;
      r_resp  <= '0;
      r_cnt   <= '0;
      r_clr   <= 1'b0;
      r_send  <= 1'b0;
      r_strt  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_clr  <= 1'b0;
      r_send <= 1'b0;
      r_strt <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (u_if.cmd_rdy) begin
            r_cmd   <= u_if.cmd;
            r_clr   <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= S_DECODE;
          end
        end
        S_DECODE: begin
          r_state <= S_RESP;
          unique case (1'b1)
            w_op_cal: begin
              r_strt  <= 1'b1;
              r_cnt   <= '0;
              r_state <= S_CAL_WAIT;
            end
            w_op_ping: r_resp <= ACK;
            w_op_wr: begin
              if (w_addr_ok) begin
                r_regs[w_idx] <= w_data;
                r_resp        <= ACK;
              end else begin
                r_resp <= NAK;
              end
            end
            w_op_rd: begin
              if (w_addr_ok) r_resp <= r_regs[w_idx];
              else           r_resp <= NAK;
            end
            default: r_resp <= NAK;
          endcase
        end
        S_CAL_WAIT: begin
          r_cnt <= r_cnt + 1'b1;
          if (cal_done) begin
            r_resp  <= ACK;
            r_state <= S_RESP;
          end else if (r_cnt == CNT_LAST) begin
            r_resp  <= NAK;
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          r_send  <= 1'b1;
          r_state <= S_WAIT_SENT;
        end
        S_WAIT_SENT: begin
          if (u_if.resp_sent) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
